// File: rtl/display_pkg.sv
// Shared definitions for the ILI9341 8080 write-bus receiver.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
package display_pkg;

    // ILI9341 command opcodes understood by the receiver
    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_SLPOUT  = 8'h11;
    localparam logic [7:0] CMD_DISPOFF = 8'h28;
    localparam logic [7:0] CMD_DISPON  = 8'h29;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_PASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;
    localparam logic [7:0] CMD_MADCTL  = 8'h36;
    localparam logic [7:0] CMD_COLMOD  = 8'h3A;

    // Pixel formats: the only one we assemble, and the panel's power-on value
    localparam logic [7:0] COLMOD_RGB565 = 8'h55;
    localparam logic [7:0] COLMOD_RESET  = 8'h66;

    // Decode FSM states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PARAM  = 3'd1,
        SKIP   = 3'd2,
        PIX_HI = 3'd3,
        PIX_LO = 3'd4
    } rx_state_t;

    // One synchronizer stage worth of bus pins, kept together so they stay aligned
    typedef struct packed {
        logic       wr;
        logic       cs;
        logic       dc;
        logic [7:0] data;
    } bus_sample_t;

    // Column/page address window (full 16-bit values as written by the host)
    typedef struct packed {
        logic [15:0] xs;
        logic [15:0] xe;
        logic [15:0] ys;
        logic [15:0] ye;
    } window_t;

    // Commands followed by a parameter phase
    function automatic logic cmd_has_params(input logic [7:0] code);
        return (code == CMD_CASET) || (code == CMD_PASET) ||
               (code == CMD_MADCTL) || (code == CMD_COLMOD);
    endfunction

    // Commands whose parameter phase is a single byte
    function automatic logic cmd_single_param(input logic [7:0] code);
        return (code == CMD_MADCTL) || (code == CMD_COLMOD);
    endfunction

endpackage

// File: rtl/display_bus_sampler.sv
// Synchronizes the 8080 bus pins as one bundle and emits a strobe per written byte.
// Latency: byte_stb/byte_dc/byte_data valid SYNC_STAGES+1 aclk edges after lcd_wr is first sampled high.
// Backpressure: none; the host bus cannot be stalled, every qualified wr edge yields one strobe.
module display_bus_sampler
    import display_pkg::*;
#(
    parameter int SYNC_STAGES = 2    // legal range 1..4
) (
    input  logic       aclk,
    input  logic       areset,
    input  logic [7:0] lcd_data,
    input  logic       lcd_wr,
    input  logic       lcd_cs,
    input  logic       lcd_dc,
    output logic       byte_stb,
    output logic       byte_dc,
    output logic [7:0] byte_data
);

    // Idle bus: deselected, strobe high, so leaving reset never fakes an edge
    localparam bus_sample_t BUS_IDLE = '{wr: 1'b1, cs: 1'b1, dc: 1'b0, data: 8'h00};

    bus_sample_t [SYNC_STAGES-1:0] sync_q;
    bus_sample_t                   bus_in;
    bus_sample_t                   bus_s;
    logic                          wr_prev;

    assign bus_in = '{wr: lcd_wr, cs: lcd_cs, dc: lcd_dc, data: lcd_data};
    assign bus_s  = sync_q[SYNC_STAGES-1];

    // Shift all pins through the same number of flops so data/dc/cs line up with wr
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= BUS_IDLE;
            end
        end else begin
            sync_q[0] <= bus_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    // Rising edge of synced wr while selected latches one byte event
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_prev   <= 1'b1;
            byte_stb  <= 1'b0;
            byte_dc   <= 1'b0;
            byte_data <= 8'h00;
        end else begin
            wr_prev   <= bus_s.wr;
            byte_stb  <= bus_s.wr & ~wr_prev & ~bus_s.cs;
            byte_dc   <= bus_s.dc;
            byte_data <= bus_s.data;
        end
    end

endmodule

// File: rtl/display_bus_receiver.sv
// Decodes ILI9341 8080 writes: command/parameter tracking, address window, RGB565 pixel stream with coordinates.
// Latency: tvalid rises SYNC_STAGES+2 aclk edges after lcd_wr is first sampled high for a pixel's low byte.
// Backpressure: single-entry output register; a pixel completing while it is full is dropped and sets overflow.
// Optional DISPLAY_RX_CMD_TRACE_EN adds cmd_valid/cmd_code, a one-cycle pulse per command byte.
module display_bus_receiver
    import display_pkg::*;
#(
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 320,
    parameter int SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic [7:0]  lcd_data,
    input  logic        lcd_wr,
    input  logic        lcd_rd,
    input  logic        lcd_cs,
    input  logic        lcd_dc,
    input  logic        lcd_rst,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic [15:0] m_axis_tdata,
    output logic        m_axis_tlast,
    output logic [8:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic [7:0]  madctl,
    output logic [7:0]  colmod,
    output logic        display_on,
    output logic        sleep_out,
    output logic        overflow,
    output logic        fmt_err
`ifdef DISPLAY_RX_CMD_TRACE_EN
    ,
    output logic        cmd_valid,
    output logic [7:0]  cmd_code
`endif
);

    localparam window_t WIN_RESET = '{
        xs: 16'd0, xe: 16'(WIDTH - 1),
        ys: 16'd0, ye: 16'(HEIGHT - 1)
    };

    // Reads are not modelled; the strobe is accepted and ignored
    logic unused_rd;
    assign unused_rd = lcd_rd;

    logic       byte_stb;
    logic       byte_dc;
    logic [7:0] byte_data;

    display_bus_sampler #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sampler (
        .aclk      (aclk),
        .areset    (areset),
        .lcd_data  (lcd_data),
        .lcd_wr    (lcd_wr),
        .lcd_cs    (lcd_cs),
        .lcd_dc    (lcd_dc),
        .byte_stb  (byte_stb),
        .byte_dc   (byte_dc),
        .byte_data (byte_data)
    );

    rx_state_t   state;
    logic [1:0]  param_idx;
    logic [7:0]  cur_cmd;
    logic [23:0] param_buf;
    logic [7:0]  hi_byte;
    logic [15:0] cur_x;
    logic [15:0] cur_y;
    window_t     win;

    logic        cmd_stb;
    logic        dat_stb;
    logic        pix_done;
    logic        pix_last;
    logic        in_pixels;
    logic        out_free;
    logic [15:0] pix_word;

    assign cmd_stb   = byte_stb & ~byte_dc;
    assign dat_stb   = byte_stb &  byte_dc;
    assign in_pixels = (state == PIX_HI) || (state == PIX_LO);
    assign pix_done  = dat_stb && (state == PIX_LO);
    assign pix_word  = {hi_byte, byte_data};
    // >= rather than == keeps a degenerate window (start > end) on one row/column
    assign pix_last  = (cur_x >= win.xe) && (cur_y >= win.ye);
    assign out_free  = !m_axis_tvalid || m_axis_tready;

    // Decode FSM: command dispatch, parameter collection, pixel byte pairing and cursor
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= IDLE;
            param_idx <= 2'd0;
            cur_cmd   <= 8'h00;
            param_buf <= 24'h0;
            hi_byte   <= 8'h00;
            cur_x     <= 16'd0;
            cur_y     <= 16'd0;
        end else if (!lcd_rst) begin
            state     <= IDLE;
            param_idx <= 2'd0;
            cur_cmd   <= 8'h00;
            param_buf <= 24'h0;
            hi_byte   <= 8'h00;
            cur_x     <= 16'd0;
            cur_y     <= 16'd0;
        end else if (cmd_stb) begin
            // Any command abandons partial parameters and a pending high byte
            cur_cmd   <= byte_data;
            param_idx <= 2'd0;
            if (cmd_has_params(byte_data)) begin
                state <= PARAM;
            end else if (byte_data == CMD_RAMWR) begin
                state <= PIX_HI;
                cur_x <= win.xs;
                cur_y <= win.ys;
            end else begin
                state <= SKIP;
            end
        end else if (dat_stb) begin
            case (state)
                PARAM: begin
                    param_buf <= {param_buf[15:0], byte_data};
                    param_idx <= param_idx + 2'd1;
                    if (cmd_single_param(cur_cmd) || (param_idx == 2'd3)) begin
                        state <= SKIP;
                    end
                end
                PIX_HI: begin
                    hi_byte <= byte_data;
                    state   <= PIX_LO;
                end
                PIX_LO: begin
                    state <= PIX_HI;
                    // Cursor advances even if the pixel is dropped on overflow
                    if (cur_x >= win.xe) begin
                        cur_x <= win.xs;
                        if (cur_y >= win.ye) begin
                            cur_y <= win.ys;
                        end else begin
                            cur_y <= cur_y + 16'd1;
                        end
                    end else begin
                        cur_x <= cur_x + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Configuration registers: window commit, MADCTL/COLMOD, power flags, format error
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            win        <= WIN_RESET;
            madctl     <= 8'h00;
            colmod     <= COLMOD_RESET;
            display_on <= 1'b0;
            sleep_out  <= 1'b0;
            fmt_err    <= 1'b0;
        end else if (!lcd_rst) begin
            win        <= WIN_RESET;
            madctl     <= 8'h00;
            colmod     <= COLMOD_RESET;
            display_on <= 1'b0;
            sleep_out  <= 1'b0;
            fmt_err    <= 1'b0;
        end else begin
            if (cmd_stb) begin
                case (byte_data)
                    CMD_SWRESET: begin
                        win        <= WIN_RESET;
                        madctl     <= 8'h00;
                        colmod     <= COLMOD_RESET;
                        display_on <= 1'b0;
                        sleep_out  <= 1'b0;
                    end
                    CMD_SLPOUT:  sleep_out  <= 1'b1;
                    CMD_DISPOFF: display_on <= 1'b0;
                    CMD_DISPON:  display_on <= 1'b1;
                    default: ;
                endcase
            end
            if (dat_stb && (state == PARAM)) begin
                case (cur_cmd)
                    // Window only changes once all four bytes have arrived
                    CMD_CASET: begin
                        if (param_idx == 2'd3) begin
                            win.xs <= param_buf[23:8];
                            win.xe <= {param_buf[7:0], byte_data};
                        end
                    end
                    CMD_PASET: begin
                        if (param_idx == 2'd3) begin
                            win.ys <= param_buf[23:8];
                            win.ye <= {param_buf[7:0], byte_data};
                        end
                    end
                    CMD_MADCTL: madctl <= byte_data;
                    CMD_COLMOD: colmod <= byte_data;
                    default: ;
                endcase
            end
            if (dat_stb && in_pixels && (colmod != COLMOD_RGB565)) begin
                fmt_err <= 1'b1;
            end
        end
    end

    // Output register: load on completion when free, else drop and flag overflow
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 16'h0000;
            m_axis_tlast  <= 1'b0;
            pixel_x       <= 9'd0;
            pixel_y       <= 9'd0;
            overflow      <= 1'b0;
        end else if (!lcd_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 16'h0000;
            m_axis_tlast  <= 1'b0;
            pixel_x       <= 9'd0;
            pixel_y       <= 9'd0;
            overflow      <= 1'b0;
        end else if (pix_done && out_free) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= pix_word;
            m_axis_tlast  <= pix_last;
            pixel_x       <= cur_x[8:0];
            pixel_y       <= cur_y[8:0];
        end else begin
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (pix_done) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef DISPLAY_RX_CMD_TRACE_EN
    // Command trace: echo each command byte one cycle after its byte event
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
        end else if (!lcd_rst) begin
            cmd_valid <= 1'b0;
            cmd_code  <= 8'h00;
        end else begin
            cmd_valid <= cmd_stb;
            if (cmd_stb) begin
                cmd_code <= byte_data;
            end
        end
    end
`endif

endmodule

// File: tb/tb_display_bus_receiver.sv
// Scoreboard bench for display_bus_receiver driving directed 8080 write sequences.
// Latency: n/a.
// Backpressure: tready is held low in the overflow and reset scenarios.
module tb_display_bus_receiver;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [7:0]  lcd_data = 8'h00;
    logic        lcd_wr = 1'b1;
    logic        lcd_rd = 1'b1;
    logic        lcd_cs = 1'b1;
    logic        lcd_dc = 1'b0;
    logic        lcd_rst = 1'b1;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [15:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [8:0]  pixel_x;
    logic [8:0]  pixel_y;
    logic [7:0]  madctl;
    logic [7:0]  colmod;
    logic        display_on;
    logic        sleep_out;
    logic        overflow;
    logic        fmt_err;
`ifdef DISPLAY_RX_CMD_TRACE_EN
    logic        cmd_valid;
    logic [7:0]  cmd_code;
`endif

    always #5 aclk = ~aclk;

    display_bus_receiver dut (
        .aclk          (aclk),
        .areset        (areset),
        .lcd_data      (lcd_data),
        .lcd_wr        (lcd_wr),
        .lcd_rd        (lcd_rd),
        .lcd_cs        (lcd_cs),
        .lcd_dc        (lcd_dc),
        .lcd_rst       (lcd_rst),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tlast  (m_axis_tlast),
        .pixel_x       (pixel_x),
        .pixel_y       (pixel_y),
        .madctl        (madctl),
        .colmod        (colmod),
        .display_on    (display_on),
        .sleep_out     (sleep_out),
        .overflow      (overflow),
        .fmt_err       (fmt_err)
`ifdef DISPLAY_RX_CMD_TRACE_EN
        ,
        .cmd_valid     (cmd_valid),
        .cmd_code      (cmd_code)
`endif
    );

    typedef struct packed {
        logic [15:0] d;
        logic [8:0]  x;
        logic [8:0]  y;
        logic        l;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every accepted beat is matched against the oldest expected pixel
    initial begin : monitor
        exp_t got;
        exp_t want;
        forever begin
            @(negedge aclk);
            if (m_axis_tvalid && m_axis_tready) begin
                got = '{d: m_axis_tdata, x: pixel_x, y: pixel_y, l: m_axis_tlast};
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_pixel: got data=%h x=%0d y=%0d last=%0d, required no output",
                             got.d, got.x, got.y, got.l);
                end else begin
                    want = exp_q.pop_front();
                    if (got !== want) begin
                        n_err++;
                        $display("FAIL pixel_out: got data=%h x=%0d y=%0d last=%0d, required data=%h x=%0d y=%0d last=%0d",
                                 got.d, got.x, got.y, got.l, want.d, want.x, want.y, want.l);
                    end
                end
            end
        end
    end

    // One 8080 write: setup with wr low, then rising wr latches the byte
    task automatic bus_byte(input logic dc, input logic [7:0] d, input logic cs);
        @(posedge aclk); #1;
        lcd_cs   = cs;
        lcd_dc   = dc;
        lcd_data = d;
        lcd_wr   = 1'b0;
        repeat (3) @(posedge aclk);
        #1 lcd_wr = 1'b1;
        repeat (3) @(posedge aclk);
    endtask

    task automatic cmd(input logic [7:0] c);
        bus_byte(1'b0, c, 1'b0);
    endtask

    task automatic dat(input logic [7:0] d);
        bus_byte(1'b1, d, 1'b0);
    endtask

    task automatic pixel(input logic [15:0] p, input logic [8:0] px, input logic [8:0] py,
                         input logic pl, input logic expect_out);
        dat(p[15:8]);
        if (expect_out) exp_q.push_back('{d: p, x: px, y: py, l: pl});
        dat(p[7:0]);
    endtask

    task automatic settle();
        repeat (4) @(posedge aclk);
        #1;
    endtask

    initial begin : stimulus
        // Reset state
        repeat (3) @(posedge aclk);
        #1;
        check("rst_tvalid",     32'(m_axis_tvalid), 32'd0);
        check("rst_colmod",     32'(colmod),        32'h66);
        check("rst_madctl",     32'(madctl),        32'h00);
        check("rst_display_on", 32'(display_on),    32'd0);
        check("rst_sleep_out",  32'(sleep_out),     32'd0);
        check("rst_overflow",   32'(overflow),      32'd0);
        check("rst_fmt_err",    32'(fmt_err),       32'd0);
        areset = 1'b0;

        // Default window; a byte written with cs high must be ignored
        cmd(8'h2C);
        bus_byte(1'b1, 8'h55, 1'b1);
        pixel(16'hF800, 9'd0, 9'd0, 1'b0, 1'b1);
        pixel(16'hF800, 9'd1, 9'd0, 1'b0, 1'b1);
        settle();
        check("fmt_err_colmod66", 32'(fmt_err), 32'd1);

        // 2x2 window, wrap back to origin on the fifth pixel
        cmd(8'h2A); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
        cmd(8'h2B); dat(8'h00); dat(8'h00); dat(8'h00); dat(8'h01);
        cmd(8'h2C);
        pixel(16'h1234, 9'd0, 9'd0, 1'b0, 1'b1);
        pixel(16'h5678, 9'd1, 9'd0, 1'b0, 1'b1);
        pixel(16'h9ABC, 9'd0, 9'd1, 1'b0, 1'b1);
        pixel(16'hDEF0, 9'd1, 9'd1, 1'b1, 1'b1);
        pixel(16'h0F0F, 9'd0, 9'd0, 1'b0, 1'b1);
        settle();

        // Config registers then software reset
        cmd(8'h36); dat(8'h68);
        cmd(8'h3A); dat(8'h55);
        cmd(8'h11);
        cmd(8'h29);
        settle();
        check("madctl_set",     32'(madctl),     32'h68);
        check("colmod_set",     32'(colmod),     32'h55);
        check("display_on_set", 32'(display_on), 32'd1);
        check("sleep_out_set",  32'(sleep_out),  32'd1);
        cmd(8'h01);
        settle();
        check("madctl_swrst",     32'(madctl),     32'h00);
        check("colmod_swrst",     32'(colmod),     32'h66);
        check("display_on_swrst", 32'(display_on), 32'd0);
        check("sleep_out_swrst",  32'(sleep_out),  32'd0);

        // Truncated CASET leaves the (now default) window alone
        cmd(8'h2A); dat(8'h00); dat(8'h03);
        cmd(8'h2C);
        pixel(16'hA1A2, 9'd0, 9'd0, 1'b0, 1'b1);
        pixel(16'hA3A4, 9'd1, 9'd0, 1'b0, 1'b1);
        pixel(16'hA5A6, 9'd2, 9'd0, 1'b0, 1'b1);
        // High byte then a command: nothing emitted, later data lands in SKIP
        dat(8'hAA);
        cmd(8'h00);
        dat(8'hBB);
        dat(8'hCC);
        cmd(8'h2C);
        pixel(16'h1122, 9'd0, 9'd0, 1'b0, 1'b1);
        settle();

        // Overflow: first pixel held, second dropped, cursor still advances
        cmd(8'h3A); dat(8'h55);
        cmd(8'h2C);
        #1 m_axis_tready = 1'b0;
        pixel(16'hA0A1, 9'd0, 9'd0, 1'b0, 1'b1);
        settle();
        check("ovf_hold_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("ovf_hold_tdata",  32'(m_axis_tdata),  32'hA0A1);
        check("ovf_not_yet",     32'(overflow),      32'd0);
        pixel(16'hB0B1, 9'd1, 9'd0, 1'b0, 1'b0);
        settle();
        check("ovf_flag",        32'(overflow),      32'd1);
        check("ovf_stable_data", 32'(m_axis_tdata),  32'hA0A1);
        check("ovf_stable_x",    32'(pixel_x),       32'd0);
        m_axis_tready = 1'b1;
        pixel(16'hC0C1, 9'd2, 9'd0, 1'b0, 1'b1);
        settle();

        // lcd_rst low for one edge clears decode state and sticky flags
        cmd(8'h36); dat(8'h22);
        settle();
        check("madctl_pre_lcdrst", 32'(madctl), 32'h22);
        lcd_rst = 1'b0;
        @(posedge aclk); #1;
        lcd_rst = 1'b1;
        check("madctl_lcdrst",   32'(madctl),   32'h00);
        check("colmod_lcdrst",   32'(colmod),   32'h66);
        check("overflow_lcdrst", 32'(overflow), 32'd0);
        check("fmt_err_lcdrst",  32'(fmt_err),  32'd0);

        // areset mid-PIX_LO with a held pixel drops tvalid before the next edge
        m_axis_tready = 1'b0;
        cmd(8'h2C);
        pixel(16'hD0D1, 9'd0, 9'd0, 1'b0, 1'b0);
        settle();
        check("pre_areset_tvalid", 32'(m_axis_tvalid), 32'd1);
        dat(8'hE0);
        @(posedge aclk);
        #3 areset = 1'b1;
        #1;
        check("areset_async_tvalid", 32'(m_axis_tvalid), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        m_axis_tready = 1'b1;
        dat(8'hF1);
        repeat (10) @(posedge aclk);
        #1;
        check("no_pixel_after_reset", 32'(m_axis_tvalid), 32'd0);

        // Every expected pixel must have been seen
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge aclk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/display_bus_receiver.md
Name: display_bus_receiver

Overview:
- Receive-side model of the ILI9341 8-bit 8080 write bus; the display end of what our display controller drives.
- Samples the lcd_* pins, decodes commands and parameters, tracks the column/page window and assembles RAMWR byte pairs into RGB565 pixels.
- Emits pixels with coordinates on an AXI-Stream master into the sim_lcd frame checker and framebuffer. Synthesizable, so it can also act as an on-board bus sniffer.

Parameters:
- WIDTH, 240: default column count; reset value of XE is WIDTH-1.
- HEIGHT, 320: default page count; reset value of YE is HEIGHT-1.
- SYNC_STAGES, 2: synchronizer depth applied equally to lcd_wr/cs/dc/data; legal range 1..4.

Ports:
- aclk  in  1  sole clock
- areset  in  1  asynchronous, active-high reset
- lcd_data  in  8  8080 data bus
- lcd_wr  in  1  write strobe; byte latched on rising edge
- lcd_rd  in  1  read strobe; ignored (reads unsupported)
- lcd_cs  in  1  chip select, active-low
- lcd_dc  in  1  0 = command, 1 = data
- lcd_rst  in  1  display reset, active-low; synchronous soft-reset of decode state
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tdata  out  16  RGB565, high byte first on bus
- m_axis_tlast  out  1  pixel at (XE,YE)
- pixel_x  out  9  column of current tdata
- pixel_y  out  9  page of current tdata
- madctl  out  8  last MADCTL (0x36) parameter
- colmod  out  8  last COLMOD (0x3A) parameter
- display_on  out  1  set by 0x29, cleared by 0x28/0x01
- sleep_out  out  1  set by 0x11, cleared by 0x01
- overflow  out  1  sticky; pixel dropped
- fmt_err  out  1  sticky; RAMWR data while colmod != 0x55

Behaviour:
- Reset values: areset (or lcd_rst low) clears all outputs to 0 except colmod = 0x66.
  - Window resets to XS=0, XE=WIDTH-1, YS=0, YE=HEIGHT-1.
  - FSM resets to IDLE.
- Sampling: data, dc and cs pass through SYNC_STAGES flops together with wr, so the three stay aligned.
- Byte event: one-cycle strobe when synced wr goes 0->1 while synced cs = 0. With cs = 1 the wr edge is ignored.
- Command byte (dc=0): always aborts any partial parameter collection and discards a pending high pixel byte.
  - 0x2A / 0x2B: FSM to PARAM with param_idx=0.
  - 0x36 / 0x3A: FSM to PARAM with param_idx=0.
  - 0x2C: cursor x=XS, y=YS; FSM to PIX_HI.
  - 0x01: window, madctl, colmod, display_on and sleep_out return to reset values.
  - 0x11 / 0x28 / 0x29: update flags.
  - Any other command: FSM to SKIP, where data bytes are ignored.
- PARAM state:
  - 0x2A: four bytes build the 16-bit XS[15:8], XS[7:0], XE[15:8], XE[7:0]. The window commits only on the 4th byte, then the FSM goes to SKIP.
  - 0x2B: same sequence for YS/YE.
  - 0x36 / 0x3A: one byte commits, then the FSM goes to SKIP.
- PIX_HI / PIX_LO:
  - High byte is latched; the low byte completes the pixel.
  - On completion, the next cycle presents tdata, pixel_x, pixel_y, and tlast = (x>=XE && y>=YE), with tvalid=1.
  - Cursor advance: x++, except when x>=XE, which gives x=XS and y++. When y>=YE as well, y=YS (frame wrap).
  - Using >= keeps degenerate windows (start>end) on a single row/column.
  - Coordinates are the low 9 bits of the cursor.
- Latency: tvalid rises SYNC_STAGES+2 aclk edges after the first edge that samples lcd_wr=1 for the low byte.
- Output buffering and handshake:
  - Single-entry output register; tvalid holds with stable payload until tready.
  - If a pixel completes while tvalid && !tready, the new pixel is dropped, overflow is set, and the cursor still advances.
  - Pixel completion in the same cycle as a handshake reloads the register with no bubble.
- Reset mid-transfer: areset or lcd_rst drops tvalid immediately (areset asynchronously, lcd_rst on the next edge).

Optional Feature:
- Macro: DISPLAY_RX_CMD_TRACE_EN.
- Defined: adds ports cmd_valid (1) and cmd_code (8). These pulse for one cycle, one aclk after every command byte event, for bench logging.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package display_pkg holds:
  - command localparams CMD_SWRESET 0x01, CMD_SLPOUT 0x11, CMD_DISPOFF 0x28, CMD_DISPON 0x29, CMD_CASET 0x2A, CMD_PASET 0x2B, CMD_RAMWR 0x2C, CMD_MADCTL 0x36, CMD_COLMOD 0x3A;
  - COLMOD_RGB565 0x55;
  - the FSM state enum (IDLE, PARAM, SKIP, PIX_HI, PIX_LO).
- One sub-module, display_bus_sampler: the SYNC_STAGES synchronizer plus wr rising-edge detect. It outputs byte_stb, byte_dc, byte_data.

Test Plan:
- Default window, RAMWR then bytes 0xF8,0x00 ×2 -> tdata 0xF800 at (0,0), then (1,0); tlast=0.
- CASET 0,0,0,1 + PASET 0,0,0,1, RAMWR, 4 pixels -> coordinates (0,0),(1,0),(0,1),(1,1); tlast only on the 4th. A 5th pixel wraps to (0,0).
- Hold tready=0 with colmod=0x55 and send 2 pixels -> the first is held stable, the second is dropped, overflow=1. After tready=1 the next pixel reports x=2.
- CASET with only 2 params then RAMWR -> window unchanged (XE=239). A high byte followed by a command -> no pixel emitted.
- 0x36 param 0x68, 0x3A param 0x55, 0x29, then 0x01 -> madctl 0x68, colmod 0x55, display_on 1, then all revert (colmod 0x66).
- Assert areset mid-PIX_LO with tvalid high -> tvalid=0 asynchronously. A following low byte with no RAMWR yields no output.
